// File: rtl/slot_sensor_conditioner.sv
// Parking slot sensor front end: synchronise, debounce and edge-detect each sensor, serialise
// exit events to at most one per cycle, and publish occupancy status.
module slot_sensor_conditioner #(
  parameter int unsigned NUM_SLOTS       = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 400000,
  parameter int unsigned DB_W            = 20,
  parameter int unsigned CNT_W           = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_SLOTS-1:0] sensor_raw,
  output logic [NUM_SLOTS-1:0] car_entry,
  output logic [NUM_SLOTS-1:0] car_exit,
  output logic [NUM_SLOTS-1:0] occupied,
  output logic [CNT_W-1:0]     occupied_count,
  output logic                 lot_full
);

  localparam logic [DB_W-1:0] DbMax = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_SLOTS-1:0] sync1_q, sync2_q;
  logic [NUM_SLOTS-1:0] stable_q, stable_d;
  logic [NUM_SLOTS-1:0] stable_dly_q;
  logic [DB_W-1:0]      cnt_q [NUM_SLOTS];
  logic [DB_W-1:0]      cnt_d [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] exit_pending_q, exit_pending_d;
  logic [NUM_SLOTS-1:0] car_entry_q, car_entry_d;
  logic [NUM_SLOTS-1:0] car_exit_q, car_exit_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 lot_full_q;

  logic [NUM_SLOTS-1:0] rise, fall, req;

  // A level must disagree with stable for DEBOUNCE_CYCLES consecutive edges to be accepted.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == DbMax) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Merged pending exits are served lowest index first, one per cycle.
  always_comb begin
    rise           = stable_q & ~stable_dly_q;
    fall           = ~stable_q & stable_dly_q;
    req            = exit_pending_q | fall;
    car_exit_d     = req & (~req + NUM_SLOTS'(1));
    exit_pending_d = req & ~car_exit_d;
    car_entry_d    = rise;
    count_d        = '0;
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      count_d = count_d + CNT_W'(stable_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q        <= '0;
      sync2_q        <= '0;
      stable_q       <= '0;
      stable_dly_q   <= '0;
      exit_pending_q <= '0;
      car_entry_q    <= '0;
      car_exit_q     <= '0;
      count_q        <= '0;
      lot_full_q     <= 1'b0;
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q        <= sensor_raw;
      sync2_q        <= sync1_q;
      stable_q       <= stable_d;
      stable_dly_q   <= stable_q;
      exit_pending_q <= exit_pending_d;
      car_entry_q    <= car_entry_d;
      car_exit_q     <= car_exit_d;
      count_q        <= count_d;
      lot_full_q     <= &stable_q;
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // stable_dly_q is loaded from stable_q on the same edge as the status registers.
  assign occupied       = stable_dly_q;
  assign car_entry      = car_entry_q;
  assign car_exit       = car_exit_q;
  assign occupied_count = count_q;
  assign lot_full       = lot_full_q;

endmodule

// File: tb/tb_slot_sensor_conditioner.sv
// Self-checking bench for slot_sensor_conditioner: directed scenarios with literal expectations
// plus randomized sensor activity checked every cycle against a behavioural model.
module tb_slot_sensor_conditioner;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sensor_raw;
  logic [3:0] car_entry, car_exit, occupied;
  logic [2:0] occupied_count;
  logic       lot_full;

  int checks = 0;
  int errors = 0;

  slot_sensor_conditioner #(
    .NUM_SLOTS(4),
    .DEBOUNCE_CYCLES(D),
    .DB_W(3),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sensor_raw(sensor_raw),
    .car_entry(car_entry),
    .car_exit(car_exit),
    .occupied(occupied),
    .occupied_count(occupied_count),
    .lot_full(lot_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: raw reaches the debouncer two edges late; a slot's stable level flips
  // after D consecutive disagreeing samples; exits queue as a set drained lowest index first.
  logic [3:0] m_s1, m_s2, m_stab, m_prev, m_pend;
  logic [3:0] m_entry, m_exit, m_occ;
  int         m_run [4];
  bit         m_live = 1'b0;

  always @(posedge clk) begin
    logic [3:0] req, low;
    if (!reset) begin
      m_s1 = '0; m_s2 = '0; m_stab = '0; m_prev = '0; m_pend = '0;
      m_entry = '0; m_exit = '0; m_occ = '0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      m_live = 1'b1;
    end else if (m_live) begin
      m_entry = m_stab & ~m_prev;
      req     = m_pend | (~m_stab & m_prev);
      low     = 4'(req & (~req + 4'd1));
      m_exit  = low;
      m_pend  = req & ~low;
      m_occ   = m_stab;
      m_prev  = m_stab;
      for (int i = 0; i < 4; i++) begin
        if (m_s2[i] != m_stab[i]) begin
          m_run[i]++;
          if (m_run[i] == D) begin
            m_stab[i] = m_s2[i];
            m_run[i]  = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = sensor_raw;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("model_entry", {4'd0, car_entry}, {4'd0, m_entry});
      chk("model_exit", {4'd0, car_exit}, {4'd0, m_exit});
      chk("model_occupied", {4'd0, occupied}, {4'd0, m_occ});
      chk("model_count", {5'd0, occupied_count}, 8'($countones(m_occ)));
      chk("model_full", {7'd0, lot_full}, {7'd0, &m_occ});
      chk("exit_onehot0", {7'd0, $onehot0(car_exit)}, 8'd1);
      chk("entry_exit_overlap", {4'd0, car_entry & car_exit}, 8'd0);
    end
  end

  task automatic drive(input logic [3:0] v);
    @(posedge clk);
    #1 sensor_raw = v;
  endtask

  task automatic step_to(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset      = 1'b0;
    sensor_raw = '0;
    step_to(3);
    chk("reset_entry", {4'd0, car_entry}, 8'h0);
    chk("reset_exit", {4'd0, car_exit}, 8'h0);
    chk("reset_occupied", {4'd0, occupied}, 8'h0);
    chk("reset_count", {5'd0, occupied_count}, 8'h0);
    chk("reset_full", {7'd0, lot_full}, 8'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    step_to(4);

    // Single arrival: pulse after edge E+7 only.
    drive(4'b0001);
    step_to(6);
    chk("s1_entry_early", {4'd0, car_entry}, 8'h0);
    chk("s1_occ_early", {4'd0, occupied}, 8'h0);
    step_to(1);
    chk("s1_entry", {4'd0, car_entry}, 8'h1);
    chk("s1_occ", {4'd0, occupied}, 8'h1);
    chk("s1_count", {5'd0, occupied_count}, 8'd1);
    chk("s1_full", {7'd0, lot_full}, 8'd0);
    step_to(1);
    chk("s1_entry_once", {4'd0, car_entry}, 8'h0);

    // Glitches on slot 2 never get accepted.
    drive(4'b0101);
    @(posedge clk);
    drive(4'b0001);
    for (int g = 0; g < 2; g++) begin
      drive(4'b0101);
      repeat (2) @(posedge clk);
      drive(4'b0001);
      repeat (2) @(posedge clk);
    end
    for (int k = 0; k < 10; k++) begin
      step_to(1);
      chk("s2_no_entry", {4'd0, car_entry}, 8'h0);
      chk("s2_occ", {4'd0, occupied}, 8'h1);
    end

    // Simultaneous departures of slots 1 and 3 are serialised.
    drive(4'b1011);
    step_to(10);
    drive(4'b0001);
    step_to(7);
    chk("s3_exit_a", {4'd0, car_exit}, 8'h2);
    chk("s3_occ", {4'd0, occupied}, 8'h1);
    step_to(1);
    chk("s3_exit_b", {4'd0, car_exit}, 8'h8);
    step_to(1);
    chk("s3_exit_done", {4'd0, car_exit}, 8'h0);

    // Full lot, then one departure.
    drive(4'b0000);
    step_to(10);
    drive(4'b1111);
    step_to(7);
    chk("s4_entry", {4'd0, car_entry}, 8'hf);
    chk("s4_count", {5'd0, occupied_count}, 8'd4);
    chk("s4_full", {7'd0, lot_full}, 8'd1);
    drive(4'b1110);
    step_to(7);
    chk("s4_exit", {4'd0, car_exit}, 8'h1);
    chk("s4_count_after", {5'd0, occupied_count}, 8'd3);
    chk("s4_full_after", {7'd0, lot_full}, 8'd0);

    // Late fall on slot 2 merges ahead of pending slot 3.
    drive(4'b1101);
    step_to(10);
    drive(4'b0100);
    drive(4'b0000);
    step_to(6);
    chk("s5_exit_0", {4'd0, car_exit}, 8'h1);
    step_to(1);
    chk("s5_exit_2", {4'd0, car_exit}, 8'h4);
    step_to(1);
    chk("s5_exit_3", {4'd0, car_exit}, 8'h8);
    step_to(1);
    chk("s5_exit_none", {4'd0, car_exit}, 8'h0);
    chk("s5_occ", {4'd0, occupied}, 8'h0);

    // Reset mid-debounce discards progress; held sensor re-arrives after release.
    drive(4'b0010);
    step_to(3);
    @(posedge clk);
    #1 reset = 1'b0;
    step_to(2);
    chk("s6_rst_entry", {4'd0, car_entry}, 8'h0);
    chk("s6_rst_occ", {4'd0, occupied}, 8'h0);
    chk("s6_rst_count", {5'd0, occupied_count}, 8'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    step_to(6);
    chk("s6_entry_early", {4'd0, car_entry}, 8'h0);
    step_to(1);
    chk("s6_entry", {4'd0, car_entry}, 8'h2);
    chk("s6_occ", {4'd0, occupied}, 8'h2);

    // Randomized activity: alternating calm and bouncy segments, occasional resets.
    for (int seg = 0; seg < 16; seg++) begin
      int unsigned odds;
      odds = (seg % 2 == 0) ? 12 : 3;
      for (int c = 0; c < 200; c++) begin
        @(posedge clk);
        #1;
        for (int b = 0; b < 4; b++) begin
          if ($urandom_range(odds - 1) == 0) sensor_raw[b] = ~sensor_raw[b];
        end
        reset = ($urandom_range(499) == 0) ? 1'b0 : 1'b1;
      end
    end
    #1 reset = 1'b1;
    step_to(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
